// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the iterative multiplier.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/Adder_32bits.sv
// 32-bit ripple-style adder with carry in/out, reused by the multiplier datapath.
module Adder_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/mult_unit.sv
// Shift-and-add 32x32 multiplier producing HI/LO after 32 RUN cycles.
// Optional signed support (magnitude multiply, negate at DONE) under MULT_SIGNED_EN.
module mult_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q, mplier_q, acc_q, hi_q, lo_q;
  logic               neg_q, busy_q, done_q;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH:0]     part;
  logic [2*WIDTH-1:0] prod, prod_fin;
  logic [WIDTH-1:0]   a_op_d, b_op_d;
  logic               neg_d;

  Adder_32bits u_add (
    .a    (acc_q),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifndef MULT_SIGNED_EN
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
`endif

  always_comb begin
    part     = mplier_q[0] ? {add_cout, add_sum} : {1'b0, acc_q};
    // Product as it will look after the final shift of the 32nd RUN cycle.
    prod     = {part, mplier_q[WIDTH-1:1]};
    prod_fin = neg_q ? -prod : prod;
    a_op_d   = A;
    b_op_d   = B;
    neg_d    = 1'b0;
`ifdef MULT_SIGNED_EN
    if (signed_op) begin
      a_op_d = A[WIDTH-1] ? -A : A;
      b_op_d = B[WIDTH-1] ? -B : B;
      neg_d  = A[WIDTH-1] ^ B[WIDTH-1];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a_op_d;
            mplier_q <= b_op_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= part[WIDTH:1];
          mplier_q <= {part[0], mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            {hi_q, lo_q} <= prod_fin;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: expected products and done cycles are queued at start.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        rst, start, signed_op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  mult_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    bit          use_sign;
    use_sign = s;
`ifndef MULT_SIGNED_EN
    use_sign = 1'b0;
`endif
    ea = {32'b0, a};
    eb = {32'b0, b};
    if (use_sign) begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end
    return ea * eb;
  endfunction

  // Output side of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("product", {hi, lo}, e.prod);
        check("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Call right after a negedge; start is sampled at the next posedge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit accept);
    exp_t e;
    A = a; B = b; signed_op = s; start = 1'b1;
    if (accept) begin
      e.prod = model(a, b, s);
      e.due  = cyc + 33;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int unsigned max_cyc);
    for (int unsigned i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  logic [31:0] va[6];
  logic [31:0] vb[6];
  logic        vs[6];

  initial begin
    int          bc;
    int unsigned d1;

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 7 x 6 with busy-cycle count
    launch(32'd7, 32'd6, 1'b0, 1'b1);
    bc = int'(busy);
    repeat (39) begin
      @(negedge clk);
      bc += int'(busy);
    end
    check("busy_cycles", 64'(bc), 64'd32);
    drain(50);
    check("lo_7x6", 64'(lo), 64'h2A);

    va = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0,        32'h80000000, 32'h80000000};
    vb = '{32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'd1};
    vs = '{1'b0,         1'b1,         1'b1,         1'b0,         1'b1,         1'b1};
    for (int i = 0; i < 6; i++) begin
      launch(va[i], vb[i], vs[i], 1'b1);
      drain(50);
    end
    for (int i = 0; i < 6; i++) begin
      launch($urandom, $urandom, 1'(i & 1), 1'b1);
      drain(50);
    end

    // start during RUN must be ignored
    launch(32'd10, 32'd20, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    launch(32'd99, 32'd77, 1'b0, 1'b0);
    drain(50);

    // reset mid-run abandons the operation
    launch(32'd1234, 32'd5678, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    launch(32'd1234, 32'd5678, 1'b0, 1'b1);
    drain(50);

    // back-to-back: new start during the DONE cycle
    @(negedge clk);
    d1 = cyc + 33;
    launch(32'd5, 32'd9, 1'b0, 1'b1);
    while (cyc < d1) @(negedge clk);
    launch(32'd3, 32'd4, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("b2b_busy",    64'(busy), 64'd1);
    check("b2b_hold_lo", 64'(lo),   64'd45);
    check("b2b_hold_hi", 64'(hi),   64'd0);
    drain(50);
    check("b2b_lo", 64'(lo), 64'hC);
    repeat (2) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand width; only 32 is supported in this CPU.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 start  input  1  one-cycle request to begin a multiply.
REQ-006 signed_op  input  1  1 = MULT (signed), 0 = MULTU (unsigned); sampled with start.
REQ-007 A  input  32  multiplicand; sampled with start.
REQ-008 B  input  32  multiplier; sampled with start.
REQ-009 busy  output  1  high while a multiply is in progress.
REQ-010 done  output  1  one-cycle pulse when hi/lo become valid.
REQ-011 hi  output  32  upper product word (HI register).
REQ-012 lo  output  32  lower product word (LO register).

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL latch A, B and signed_op, clear the accumulator, load the iteration counter with 0 and enter RUN.
REQ-015 start while in RUN SHALL be ignored; operands and progress are unaffected.
REQ-016 Each RUN cycle: if the multiplier LSB is 1, the 33-bit value {cout,sum} = acc_hi + multiplicand SHALL be formed; otherwise {0,acc_hi}. {that value, multiplier} SHALL then shift right one bit.
REQ-017 The counter SHALL increment every RUN cycle; after the 32nd RUN cycle the FSM SHALL enter DONE.
REQ-018 Latency: start sampled at edge N SHALL give done=1 in the cycle after edge N+32; this holds for every operand value, including zero.
REQ-019 On entry to DONE, hi/lo SHALL be written with the 64-bit product, and done SHALL be high for exactly that one cycle.
REQ-020 DONE SHALL return to IDLE next cycle unless start=1 (back-to-back accepted).
REQ-021 hi/lo SHALL hold their last product until the next DONE entry; they SHALL NOT change during RUN.
REQ-022 busy SHALL be 1 exactly in RUN.
REQ-023 Unsigned arithmetic SHALL be exact modulo 2^64; no overflow indication exists.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and all internal operand registers to 0.
REQ-025 Reset during RUN SHALL abandon the operation; no done pulse SHALL follow.
REQ-026 After rst deasserts, the first start SHALL behave per REQ-014.

Configuration
REQ-027 Macro MULT_SIGNED_EN defined: with signed_op=1, magnitudes of A and B SHALL be multiplied; the 64-bit result SHALL be two's-complement negated at DONE entry when A[31] XOR B[31]. Latency is unchanged.
REQ-028 MULT_SIGNED_EN undefined: signed_op SHALL be ignored and every operation SHALL be unsigned; the port remains present.

Structure
REQ-029 Package mult_pkg SHALL hold the WIDTH constant, the counter width (6 bits), and the IDLE/RUN/DONE state encoding.
REQ-030 Each RUN-cycle accumulate SHALL use one instance of the team's existing 32-bit adder Adder_32bits (cin=0); its sum and cout form the 33-bit partial sum.
REQ-031 No other sub-modules; negation logic stays inline under MULT_SIGNED_EN.

Verification
REQ-032 Unsigned 7 x 6: start at edge 0 -> done in the cycle after edge 32; hi=0x00000000, lo=0x0000002A; busy high for 32 cycles.
REQ-033 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 MULT_SIGNED_EN set, signed -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed -1 x -1 -> hi=0, lo=1. Without the macro, the same -3 x 5 with signed_op=1 -> hi=0x00000004, lo=0xFFFFFFF1 (unsigned).
REQ-035 start pulsed again at RUN cycle 5 with different operands -> ignored; the first product is delivered at the original time.
REQ-036 rst asserted at RUN cycle 10 -> busy=0, hi=lo=0 at once, no done pulse; a new start after release -> correct product at full latency.
REQ-037 Back-to-back: start held high in the DONE cycle with 3 x 4 -> the first product is shown, then 32 cycles later lo=0x0000000C.
